// File: rtl/serial_subtractor_sv_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// Optional oOVF wire exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_sv_if #(
  parameter int WIDTH = 8
);
  logic             iVALID;
  logic             oREADY;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic             iBIN;
  logic             iABORT;
  logic             oVALID;
  logic             iREADY;
  logic [WIDTH-1:0] oDIFF;
  logic             oBOUT;
  logic             oBUSY;
`ifdef SERIAL_SUB_OVF_EN
  logic             oOVF;
`endif

  modport slave (
    input  iVALID, iA, iB, iBIN, iABORT, iREADY,
`ifdef SERIAL_SUB_OVF_EN
    output oOVF,
`endif
    output oREADY, oVALID, oDIFF, oBOUT, oBUSY
  );

  modport master (
    output iVALID, iA, iB, iBIN, iABORT, iREADY,
`ifdef SERIAL_SUB_OVF_EN
    input  oOVF,
`endif
    input  oREADY, oVALID, oDIFF, oBOUT, oBUSY
  );
endinterface

// File: rtl/serial_subtractor_sv.sv
// Bit-serial A - B - BIN, LSB first, one full-subtractor cell with a registered borrow.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output oOVF.
module serial_subtractor_sv #(
  parameter int WIDTH = 8
) (
  input logic                  iCLK,
  input logic                  iRST_N,
  serial_subtractor_sv_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for operands, oREADY high
  // RUN   | shifting one bit per clock through the subtractor cell
  // DONE  | result held on oDIFF/oBOUT until downstream takes it
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = $clog2(WIDTH);

  state_t           state, nextState;
  logic [WIDTH-1:0] shiftA, shiftB, shiftD, diffReg;
  logic             borrowReg, boutReg;
  logic [CW-1:0]    cnt;
  logic             accept, finish, abortRun, lastBit;
  logic             bitA, bitB, bitD, bitBo;
`ifdef SERIAL_SUB_OVF_EN
  logic             msbBorrowIn;
`endif

  assign bitA    = shiftA[0];
  assign bitB    = shiftB[0];
  assign bitD    = bitA ^ bitB ^ borrowReg;
  assign bitBo   = (~bitA & bitB) | (~(bitA ^ bitB) & borrowReg);
  assign lastBit = (cnt == CW'(WIDTH-1));

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= IDLE;
    else         state <= nextState;
  end

  always_comb begin
    nextState = state;
    accept    = 1'b0;
    finish    = 1'b0;
    abortRun  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.iVALID) begin
          accept    = 1'b1;
          nextState = RUN;
        end
      end
      RUN: begin
        // abort wins even on the final bit, so no result escapes
        if (bus.iABORT) begin
          abortRun  = 1'b1;
          nextState = IDLE;
        end else if (lastBit) begin
          finish    = 1'b1;
          nextState = DONE;
        end
      end
      DONE: begin
        if (bus.iREADY) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      shiftA      <= '0;
      shiftB      <= '0;
      shiftD      <= '0;
      diffReg     <= '0;
      borrowReg   <= 1'b0;
      boutReg     <= 1'b0;
      cnt         <= '0;
`ifdef SERIAL_SUB_OVF_EN
      msbBorrowIn <= 1'b0;
`endif
    end else if (accept) begin
      shiftA    <= bus.iA;
      shiftB    <= bus.iB;
      shiftD    <= '0;
      borrowReg <= bus.iBIN;
      cnt       <= '0;
    end else if (abortRun) begin
      cnt       <= '0;
      borrowReg <= 1'b0;
    end else if (state == RUN) begin
      shiftA    <= shiftA >> 1;
      shiftB    <= shiftB >> 1;
      shiftD    <= {bitD, shiftD[WIDTH-1:1]};
      borrowReg <= bitBo;
      cnt       <= cnt + CW'(1);
      if (finish) begin
        diffReg     <= {bitD, shiftD[WIDTH-1:1]};
        boutReg     <= bitBo;
`ifdef SERIAL_SUB_OVF_EN
        msbBorrowIn <= borrowReg;
`endif
      end
    end
  end

  assign bus.oREADY = (state == IDLE);
  assign bus.oBUSY  = (state == RUN);
  assign bus.oVALID = (state == DONE);
  assign bus.oDIFF  = diffReg;
  assign bus.oBOUT  = boutReg;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.oOVF   = msbBorrowIn ^ boutReg;
`endif

endmodule

// File: tb/tb_serial_subtractor_sv.sv
// Scoreboard bench for serial_subtractor_sv (WIDTH=8); oOVF is checked when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor_sv;
  localparam int W = 8;
  typedef logic [W+1:0] exp_t;  // {ovf, bout, diff}

  logic iCLK = 1'b0;
  logic iRST_N = 1'b0;
  always #5 iCLK = ~iCLK;

  serial_subtractor_sv_if #(.WIDTH(W)) bus ();
  serial_subtractor_sv #(.WIDTH(W)) dut (.iCLK(iCLK), .iRST_N(iRST_N), .bus(bus.slave));

  int   checks = 0;
  int   failures = 0;
  exp_t sbQ[$];

  task automatic checkVal(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    logic [W:0] full;
    int         sr;
    logic       ovf;
    full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    sr   = int'($signed(a)) - int'($signed(b)) - int'(bin);
    ovf  = (sr < -(1 << (W-1))) || (sr > (1 << (W-1)) - 1);
    return {ovf, full[W], full[W-1:0]};
  endfunction

  always @(negedge iCLK) begin : monitor
    exp_t e;
    if (iRST_N && bus.oVALID && bus.iREADY) begin
      if (sbQ.size() == 0) checkVal("unexpected_result", 1, 0);
      else begin
        e = sbQ.pop_front();
        checkVal("diff", bus.oDIFF, e[W-1:0]);
        checkVal("bout", bus.oBOUT, e[W]);
`ifdef SERIAL_SUB_OVF_EN
        checkVal("ovf", bus.oOVF, e[W+1]);
`endif
      end
    end
  end

  task automatic startOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin, input bit push);
    int n = 0;
    bus.iA = a; bus.iB = b; bus.iBIN = bin; bus.iVALID = 1'b1;
    forever begin
      @(negedge iCLK);
      if (bus.oREADY) break;
      n++;
      if (n > 100) begin
        checkVal("accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge iCLK); #1;
    bus.iVALID = 1'b0;
    if (push) sbQ.push_back(model(a, b, bin));
  endtask

  task automatic waitValid();
    int n = 0;
    while (!bus.oVALID) begin
      @(posedge iCLK); #1;
      n++;
      if (n > 4*W) begin
        checkVal("valid_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sbQ.size() != 0) begin
      @(posedge iCLK); #1;
      n++;
      if (n > 8*W) begin
        checkVal("drain_timeout", sbQ.size(), 0);
        sbQ.delete();
        break;
      end
    end
    @(posedge iCLK); #1;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t bp;
    bit   sawValid;
    bus.iVALID = 0; bus.iA = '0; bus.iB = '0; bus.iBIN = 0;
    bus.iABORT = 0; bus.iREADY = 1;

    #12;
    checkVal("rst_ready", bus.oREADY, 1);
    checkVal("rst_valid", bus.oVALID, 0);
    checkVal("rst_diff",  bus.oDIFF, 0);
    checkVal("rst_bout",  bus.oBOUT, 0);
    checkVal("rst_busy",  bus.oBUSY, 0);
`ifdef SERIAL_SUB_OVF_EN
    checkVal("rst_ovf",   bus.oOVF, 0);
`endif
    @(posedge iCLK); #1; iRST_N = 1;

    // latency: valid exactly WIDTH edges after accept
    startOp(8'h05, 8'h03, 1'b0, 1);
    checkVal("busy_after_accept", bus.oBUSY, 1);
    checkVal("ready_in_run", bus.oREADY, 0);
    repeat (W-1) begin @(posedge iCLK); #1; end
    checkVal("lat_early", bus.oVALID, 0);
    @(posedge iCLK); #1;
    checkVal("lat_valid", bus.oVALID, 1);
    waitDrain();

    startOp(8'h03, 8'h05, 1'b0, 1);
    startOp(8'h00, 8'h00, 1'b1, 1);
    startOp(8'h80, 8'h01, 1'b0, 1);
    waitDrain();

    // backpressure, with abort ignored in DONE and a pending new operand
    bus.iREADY = 0;
    startOp(8'h3C, 8'h5A, 1'b1, 1);
    bp = model(8'h3C, 8'h5A, 1'b1);
    waitValid();
    bus.iA = 8'hA7; bus.iB = 8'h19; bus.iBIN = 0; bus.iVALID = 1; bus.iABORT = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge iCLK); #1;
      checkVal("bp_valid", bus.oVALID, 1);
      checkVal("bp_diff",  bus.oDIFF, bp[W-1:0]);
      checkVal("bp_bout",  bus.oBOUT, bp[W]);
      checkVal("bp_ready", bus.oREADY, 0);
      checkVal("bp_busy",  bus.oBUSY, 0);
    end
    bus.iABORT = 0;
    sbQ.push_back(model(8'hA7, 8'h19, 1'b0));
    bus.iREADY = 1;
    @(posedge iCLK); #1;
    checkVal("bp_release_ready", bus.oREADY, 1);
    checkVal("bp_release_busy",  bus.oBUSY, 0);
    @(posedge iCLK); #1;
    checkVal("bp_new_accept", bus.oBUSY, 1);
    bus.iVALID = 0;
    waitDrain();

    // abort in RUN
    startOp(8'h55, 8'h22, 1'b0, 0);
    @(posedge iCLK); #1;
    @(posedge iCLK); #1;
    bus.iABORT = 1;
    @(posedge iCLK); #1;
    bus.iABORT = 0;
    checkVal("abort_busy",  bus.oBUSY, 0);
    checkVal("abort_ready", bus.oREADY, 1);
    sawValid = 0;
    repeat (W+2) begin
      @(posedge iCLK); #1;
      sawValid |= bus.oVALID;
    end
    checkVal("abort_no_valid", sawValid, 0);
    startOp(8'hFF, 8'h0F, 1'b0, 1);
    waitDrain();

    // abort together with valid in IDLE: operand is accepted
    bus.iABORT = 1;
    startOp(8'h10, 8'h20, 1'b1, 1);
    bus.iABORT = 0;
    checkVal("idle_abort_accept", bus.oBUSY, 1);
    waitDrain();

    // asynchronous reset mid-RUN
    startOp(8'h12, 8'h34, 1'b1, 0);
    @(posedge iCLK); #1;
    @(posedge iCLK); #3;
    iRST_N = 0;
    #1;
    checkVal("mrst_ready", bus.oREADY, 1);
    checkVal("mrst_valid", bus.oVALID, 0);
    checkVal("mrst_diff",  bus.oDIFF, 0);
    checkVal("mrst_bout",  bus.oBOUT, 0);
    checkVal("mrst_busy",  bus.oBUSY, 0);
    @(posedge iCLK); #1;
    iRST_N = 1;
    @(posedge iCLK); #1;

    for (int i = 0; i < 256; i++) begin
      startOp(W'($urandom), W'($urandom), 1'($urandom), 1);
    end
    waitDrain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_subtractor_sv.md
Name: serial_subtractor_sv

Overview:
Bit-serial full subtractor: the sequential counterpart and inverse operation of the team's combinational full-adder cell. It accepts two WIDTH-bit operands and a borrow-in over a valid/ready handshake. It computes A - B - BIN LSB-first, one bit per clock, through a single full-subtractor cell with a registered borrow. It returns the difference and borrow-out over a second valid/ready handshake. Intended as an area-minimal arithmetic unit for slow datapaths and as a building block for a later serial divider.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..64.

Ports:
iCLK  input  1  clock; all state updates on rising edge.
iRST_N  input  1  asynchronous active-low reset.
iVALID  input  1  upstream operand valid.
oREADY  output  1  block can accept operands (high only in IDLE).
iA  input  WIDTH  minuend.
iB  input  WIDTH  subtrahend.
iBIN  input  1  borrow-in.
iABORT  input  1  synchronous abort of an operation in progress.
oVALID  output  1  result valid.
iREADY  input  1  downstream ready to take the result.
oDIFF  output  WIDTH  difference A - B - BIN, modulo 2^WIDTH.
oBOUT  output  1  borrow-out (1 when A < B + BIN, unsigned).
oBUSY  output  1  high in RUN.

Behaviour:
- Reset: asynchronous, active-low; state=IDLE, all registers cleared.
  - Output values in reset: oREADY=1, oVALID=0, oDIFF=0, oBOUT=0, oBUSY=0.
  - Reset asserted mid-operation discards the operation immediately; no result is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - oREADY=1.
  - On iVALID && oREADY at an edge: capture iA and iB into shift registers SA and SB, borrow register BR <= iBIN, bit counter CNT <= 0, result register SD <= 0; go to RUN.
- RUN, once per edge:
  - a = SA[0], b = SB[0].
  - d = a ^ b ^ BR.
  - bo = (~a & b) | (~(a ^ b) & BR).
  - SD <= {d, SD[WIDTH-1:1]}; SA and SB shift right; BR <= bo; CNT <= CNT + 1.
  - On the edge processing CNT == WIDTH-1, go to DONE.
- DONE:
  - oVALID=1; oDIFF=SD; oBOUT=BR.
  - oDIFF and oBOUT stay stable while oVALID && !iREADY (backpressure, hold indefinitely).
  - On iREADY, return to IDLE; oVALID drops at that edge.
- Latency: given accept at edge E0, oVALID is high after edge E0+WIDTH.
  - Minimum initiation interval is WIDTH+2 cycles with iREADY tied high.
  - No overlap between operations; oREADY=0 in RUN and DONE.
- iABORT:
  - In RUN: at the next edge, go to IDLE; CNT and BR are cleared; no oVALID is produced.
  - In IDLE and DONE: ignored. An already-completed result is not dropped.
  - iABORT and iVALID at the same edge in IDLE: the operand is accepted.
- oDIFF and oBOUT are registered outputs; they hold their last value outside DONE. The bench checks them only while oVALID=1.
- CNT width is clog2(WIDTH); there is no wrap, because the FSM leaves RUN at WIDTH-1.
- Wrap-around arithmetic: result modulo 2^WIDTH; borrow is reported via oBOUT only.

Optional Feature:
SERIAL_SUB_OVF_EN
- Defined: adds output port oOVF, 1 bit, reset 0, valid with oVALID.
  - oOVF is signed two's-complement overflow = (borrow into MSB) XOR (borrow out of MSB).
  - Borrow into MSB is captured in an extra register on the CNT == WIDTH-1 edge.
- Not defined: port, register and logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, A=0x05, B=0x03, BIN=0 -> after 8 RUN cycles oVALID=1, oDIFF=0x02, oBOUT=0.
- A=0x03, B=0x05, BIN=0 -> oDIFF=0xFE, oBOUT=1.
- A=0x00, B=0x00, BIN=1 -> oDIFF=0xFF, oBOUT=1. With OVF_EN: A=0x80, B=0x01, BIN=0 -> oDIFF=0x7F, oBOUT=0, oOVF=1.
- Backpressure: iREADY=0 for 5 cycles in DONE -> oVALID, oDIFF and oBOUT stable; oREADY=0; a new iVALID is not accepted until 1 cycle after iREADY=1.
- iABORT pulsed at RUN cycle 3 -> IDLE next edge, oVALID never asserts. A following A=0xFF, B=0x0F -> oDIFF=0xF0, oBOUT=0.
- iRST_N low mid-RUN (asynchronous, between edges) -> outputs immediately at reset values. After release, back-to-back 256 random operand pairs match the reference model (A - B - BIN).
